alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU with valid/ready handshakes on input and output, registered result and full flag set. It keeps the team's 3-bit operation encoding, takes the shift amount from `in1`, and executes shifts iteratively at one bit per cycle. It sits between decode and writeback in the RISC-V datapath and replaces the fixed 32-bit combinational ALU where the pipeline needs stall-tolerant execution.

## Interface
- `WIDTH`, 32: operand/result width in bits; power of two, ≥ 4.
- `SHAMT_W`, $clog2(WIDTH): derived localparam, not overridable; shift-amount field width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operand/op presented.
- `in_ready`  out  1  block accepts a transfer this cycle.
- `in0`  in  WIDTH  operand A; the value shifted for shift ops.
- `in1`  in  WIDTH  operand B; for shift ops only `in1[SHAMT_W-1:0]` is used and upper bits are ignored.
- `op`  in  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SRA, 5 NOR, 6 SRL, 7 SLL.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes result this cycle.
- `result`  out  WIDTH  registered result.
- `carry`  out  1  ADD: carry-out. SUB: 1 iff in0 ≥ in1 unsigned. Otherwise 0.
- `overflow`  out  1  signed overflow for ADD/SUB. Otherwise 0.
- `zero`  out  1  result == 0, valid for every op.
- `neg`  out  1  result[WIDTH-1], valid for every op.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- `in_ready` = rst_n && (state == IDLE || (state == DONE && out_ready)).
- Accept means `in_valid && in_ready` at a rising edge. On accept:
  - Non-shift op (0,1,2,3,5): result and flags are computed and registered; next state is DONE.
  - Shift op with shamt == 0: result = in0; next state is DONE.
  - Shift op with shamt > 0: the working register loads in0, counter = shamt, op is latched; next state is SHIFT.
- SHIFT: each cycle the working register shifts by one bit and the counter decrements.
  - SRA fills with the sign bit. SRL fills with 0. SLL shifts 0 into the LSB.
  - When the counter reaches 1, the final shift completes and the next state is DONE.
- DONE: `out_valid` = 1. Result and flags hold stable until `out_ready`.
  - `out_ready` with a simultaneous accept: a new op starts and DONE/SHIFT is re-entered per the accept rules.
  - `out_ready` without an accept: next state is IDLE.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD carry is bit WIDTH of the sum.
  - SUB uses in0 + ~in1 + 1; carry is bit WIDTH of that sum.
  - overflow = (signs of the effective operands equal) && (result sign differs).
- Flags are registered together with the result and update only when the result register updates.
- Inputs are sampled only on accept. Changes to `in0`/`in1`/`op` at other times have no effect.

## Timing
- Reset values: `result` = 0, `carry`/`overflow`/`zero`/`neg` = 0, `out_valid` = 0, state IDLE, counter 0. `in_ready` = 0 while `rst_n` is low.
- Asserting `rst_n` low mid-SHIFT or mid-DONE clears everything immediately. The in-flight op is discarded and produces no output.
- Latency, measured from the accept edge to the first edge with `out_valid` = 1:
  - non-shift op: 1 cycle.
  - shift op: shamt + 1 cycles, maximum WIDTH cycles.
- Throughput: non-shift ops sustain 1 per cycle when `out_ready` is held high. A shift op blocks `in_ready` for shamt cycles.
- `out_valid` never deasserts without `out_ready`. A result is presented exactly once.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow = 1, carry = 0, neg = 1, zero = 0; `out_valid` 1 cycle after accept.
- SUB 5 − 5 → result 0, zero = 1, carry = 1. SUB 0 − 1 → result 0xFFFFFFFF, carry = 0, neg = 1, overflow = 0. NOR 0 ~| 0 → 0xFFFFFFFF, carry = overflow = 0.
- SRA 0x80000000 by in1 = 0xFFFFFF04 (shamt 4) → 0xF8000000 after exactly 5 cycles, `in_ready` low meanwhile. SRL 0x80000000 by 31 → 0x00000001 after 32 cycles. SLL 0x12345678 by 0 → 0x12345678 after 1 cycle.
- Backpressure: ADD result with `out_ready` low for 3 cycles → result and flags stable, `out_valid` held, `in_ready` = 0. Then 4 back-to-back AND ops with `out_ready` = 1 → 4 results on 4 consecutive cycles.
- Reset mid-shift: SLL by 20, drop `rst_n` at cycle 7 → all outputs 0 immediately. After release, ADD 2 + 3 → 5 in 1 cycle, with no stale shift result emitted.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
//
// Logic and arithmetic ops (AND, OR, ADD, SUB, NOR) finish in one cycle.
// Shift ops (SRA, SRL, SLL) shift one bit per cycle.
// The result and all flags are registered together and presented once under out_valid.
//
// Ports:
//   clk, rst_n           clock (rising edge); asynchronous active-low reset
//   in_valid / in_ready  input handshake for in0, in1, op
//   in0, in1             operands; for shifts only in1[SHAMT_W-1:0] is used
//   op                   0 AND, 1 OR, 2 ADD, 3 SUB, 4 SRA, 5 NOR, 6 SRL, 7 SLL
//   out_valid / out_ready  output handshake for result and flags
//   result               registered result
//   carry, overflow, zero, neg  registered flags
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);
    localparam int SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;

    // Single-cycle datapath, evaluated on the presented inputs.
    logic [WIDTH:0]     sum_add, sum_sub;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic               is_shift, accept;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   shift_one;

    // Result-register load port; flags are derived from whatever is loaded.
    logic               load_res;
    logic [WIDTH-1:0]   load_val;
    logic               load_c, load_v;

    assign sum_add = {1'b0, in0} + {1'b0, in1};
    assign sum_sub = {1'b0, in0} + {1'b0, ~in1} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            3'd0: alu_res = in0 & in1;
            3'd1: alu_res = in0 | in1;
            3'd2: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (in0[WIDTH-1] == in1[WIDTH-1]) &&
                          (sum_add[WIDTH-1] != in0[WIDTH-1]);
            end
            3'd3: begin
                alu_res = sum_sub[WIDTH-1:0];
                alu_c   = sum_sub[WIDTH];
                // The effective second operand is ~in1, so its sign is inverted.
                alu_v   = (in0[WIDTH-1] != in1[WIDTH-1]) &&
                          (sum_sub[WIDTH-1] != in0[WIDTH-1]);
            end
            3'd5: alu_res = ~(in0 | in1);
            default: alu_res = '0;
        endcase
    end

    assign is_shift = (op == 3'd4) || (op == 3'd6) || (op == 3'd7);
    assign shamt    = in1[SHAMT_W-1:0];

    // One-bit step of the latched shift op on the working register.
    always_comb begin
        case (op_q)
            3'd4:    shift_one = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            3'd6:    shift_one = {1'b0, work_q[WIDTH-1:1]};
            default: shift_one = {work_q[WIDTH-2:0], 1'b0};
        endcase
    end

    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        load_res   = 1'b0;
        load_val   = '0;
        load_c     = 1'b0;
        load_v     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (!is_shift) begin
                        load_res = 1'b1;
                        load_val = alu_res;
                        load_c   = alu_c;
                        load_v   = alu_v;
                        state_d  = DONE;
                    end else if (shamt == '0) begin
                        load_res = 1'b1;
                        load_val = in0;
                        state_d  = DONE;
                    end else begin
                        work_d  = in0;
                        cnt_d   = shamt;
                        op_d    = op;
                        state_d = SHIFT;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = shift_one;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    load_res = 1'b1;
                    load_val = shift_one;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        result_d   = load_res ? load_val : result_q;
        carry_d    = load_res ? load_c : carry_q;
        overflow_d = load_res ? load_v : overflow_q;
        zero_d     = load_res ? (load_val == '0) : zero_q;
        neg_d      = load_res ? load_val[WIDTH-1] : neg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign neg      = neg_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (WIDTH = 32). Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in0, in1;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry, overflow, zero, neg;

    int passed = 0;
    int total  = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow),
        .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op from IDLE and let it be accepted on the next edge.
    task automatic send(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
        in_valid = 1'b1;
        op  = o;
        in0 = a;
        in1 = b;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in0 = 32'hDEAD_BEEF;   // must be ignored after accept
        in1 = 32'hDEAD_BEEF;
    endtask

    // Count cycles until out_valid (1 = visible right after the accept edge);
    // in_ready must stay low while waiting.
    task automatic wait_out(input string tag, input int exp_lat);
        int lat = 1;
        logic rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_in_ready_low_while_busy"}, 32'(rdy_seen), 32'd0);
        $display("%s: latency %0d result %h c%0b v%0b z%0b n%0b", tag, lat, result,
                 carry, overflow, zero, neg);
    endtask

    task automatic check_res(input string tag, input logic [31:0] r, input logic c,
                             input logic v, input logic z, input logic n);
        check({tag, "_result"}, result, r);
        check({tag, "_carry"}, 32'(carry), 32'(c));
        check({tag, "_overflow"}, 32'(overflow), 32'(v));
        check({tag, "_zero"}, 32'(zero), 32'(z));
        check({tag, "_neg"}, 32'(neg), 32'(n));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] and_a [4];
        logic [31:0] and_b [4];
        logic [31:0] and_r [4];
        int seen;
        and_a = '{32'hFF00FF00, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'hF0F0F0F0};
        and_b = '{32'h0F0F0F0F, 32'h12345678, 32'h55555555, 32'hFFFF0000};
        and_r = '{32'h0F000F00, 32'h12345678, 32'h00000000, 32'hF0F00000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in0 = '0; in1 = '0; op = '0;
        step(); step();
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check_res("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // ADD overflow, then backpressure for 3 cycles.
        send("add_ovf", 3'd2, 32'h7FFFFFFF, 32'h00000001);
        wait_out("add_ovf", 1);
        check_res("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check_res("bp_hold", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        consume();
        check("add_consumed_out_valid", 32'(out_valid), 32'd0);

        send("sub_eq", 3'd3, 32'd5, 32'd5);
        wait_out("sub_eq", 1);
        check_res("sub_eq", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        consume();

        send("sub_neg", 3'd3, 32'd0, 32'd1);
        wait_out("sub_neg", 1);
        check_res("sub_neg", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        consume();

        send("nor", 3'd5, 32'd0, 32'd0);
        wait_out("nor", 1);
        check_res("nor", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        consume();

        send("sra4", 3'd4, 32'h80000000, 32'hFFFFFF04);
        wait_out("sra4", 5);
        check_res("sra4", 32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b1);
        consume();

        send("srl31", 3'd6, 32'h80000000, 32'd31);
        wait_out("srl31", 32);
        check_res("srl31", 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
        consume();

        send("sll0", 3'd7, 32'h12345678, 32'd0);
        wait_out("sll0", 1);
        check_res("sll0", 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);
        consume();

        // Four back-to-back ANDs with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; op = 3'd0; in0 = and_a[i]; in1 = and_b[i];
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            step();
            check("b2b_out_valid", 32'(out_valid), 32'd1);
            check_res("b2b_and", and_r[i], 1'b0, 1'b0, and_r[i] == 32'h0, and_r[i][31]);
            $display("b2b_and[%0d]: result %h", i, result);
        end
        in_valid = 1'b0;
        step();
        check("b2b_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset in the middle of a 20-bit SLL.
        send("sll20", 3'd7, 32'h00000001, 32'd20);
        for (int i = 0; i < 6; i++) step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check_res("midrst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("midrst: out_valid %0b result %h", out_valid, result);
        step(); step();
        rst_n = 1'b1;
        step();

        send("add_after_rst", 3'd2, 32'd2, 32'd3);
        wait_out("add_after_rst", 1);
        check_res("add_after_rst", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        consume();
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("no_stale_shift_result", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
